// File: rtl/led_adder_pipe.sv
// led_adder_pipe: registered add/sub/accumulate/invert unit with a valid/ready
// handshake and a blink/overflow status LED. Optional macro: LED_ADDER_SATURATE_EN.
module led_adder_pipe #(
    parameter int WIDTH      = 8,
    parameter int BLINK_BITS = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc_q,
    output logic             led
);

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_ACC = 2'b10,
        MODE_NOT = 2'b11
    } mode_e;

    // One extra bit of headroom so the MSB is the carry (ADD/ACC) or borrow (SUB).
    function automatic logic [WIDTH:0] alu_op(
        input logic [1:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] acc
    );
        logic [WIDTH:0] r;
        r = {(WIDTH+1){1'b0}};
        case (op)
            MODE_ADD: r = {1'b0, a} + {1'b0, b};
            MODE_SUB: r = {1'b0, a} - {1'b0, b};
            MODE_ACC: r = {1'b0, acc} + {1'b0, a};
            MODE_NOT: r = {1'b0, ~a};
            default:  r = {(WIDTH+1){1'b0}};
        endcase
`ifdef LED_ADDER_SATURATE_EN
        if (r[WIDTH]) begin
            if (op == MODE_SUB) begin
                r[WIDTH-1:0] = {WIDTH{1'b0}};
            end else begin
                r[WIDTH-1:0] = {WIDTH{1'b1}};
            end
        end
`endif
        return r;
    endfunction

    logic [WIDTH-1:0]      out_data_q, out_data_d;
    logic                  out_carry_q, out_carry_d;
    logic                  out_valid_q, out_valid_d;
    logic [WIDTH-1:0]      acc_d;
    logic                  sticky_q, sticky_d;
    logic [BLINK_BITS-1:0] cnt_q, cnt_d;
    logic                  led_q, led_d;
    logic                  accept_s;
    logic [WIDTH:0]        res_s;

    // A draining result frees the register in the same cycle it is consumed.
    assign in_ready  = ena & (~out_valid_q | out_ready);
    assign accept_s  = in_valid & in_ready;
    assign res_s     = alu_op(mode, a_in, b_in, acc_q);

    assign out_data  = out_data_q;
    assign out_carry = out_carry_q;
    assign out_valid = out_valid_q;
    assign led       = led_q;

    // Next-state logic for result register, accumulator, sticky flag and blinker.
    always_comb begin
        out_data_d  = out_data_q;
        out_carry_d = out_carry_q;
        out_valid_d = out_valid_q;
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        cnt_d       = cnt_q;
        led_d       = sticky_q | cnt_q[BLINK_BITS-1];

        if (accept_s) begin
            out_data_d  = res_s[WIDTH-1:0];
            out_carry_d = res_s[WIDTH];
            out_valid_d = 1'b1;
            sticky_d    = sticky_q | res_s[WIDTH];
            if (mode == MODE_ACC) begin
                acc_d = res_s[WIDTH-1:0];
            end else begin
                acc_d = acc_q;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (ena) begin
            cnt_d = cnt_q + {{(BLINK_BITS-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= {WIDTH{1'b0}};
            out_carry_q <= 1'b0;
            out_valid_q <= 1'b0;
            acc_q       <= {WIDTH{1'b0}};
            sticky_q    <= 1'b0;
            cnt_q       <= {BLINK_BITS{1'b0}};
            led_q       <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_carry_q <= out_carry_d;
            out_valid_q <= out_valid_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
            led_q       <= led_d;
        end
    end

endmodule

// File: tb/tb_led_adder_pipe.sv
// Self-checking bench for led_adder_pipe (WIDTH=8, BLINK_BITS=4) with a result
// scoreboard; expectations follow LED_ADDER_SATURATE_EN when it is defined.
module tb_led_adder_pipe;

    logic       clk = 1'b0;
    logic       rst_n, ena, in_valid, out_ready;
    logic [7:0] a_in, b_in;
    logic [1:0] mode;
    logic       in_ready, out_carry, out_valid, led;
    logic [7:0] out_data, acc_q;

    int checks = 0;
    int errors = 0;

    logic [8:0] sb[$];
    logic       m_valid, m_sticky, m_led;
    logic [7:0] m_acc;
    logic [3:0] m_cnt;

`ifdef LED_ADDER_SATURATE_EN
    localparam logic [7:0] EXP_ADD_OVF = 8'hFF;
    localparam logic [7:0] EXP_SUB_BRW = 8'h00;
    localparam logic [7:0] EXP_ACC4    = 8'hFF;
`else
    localparam logic [7:0] EXP_ADD_OVF = 8'h10;
    localparam logic [7:0] EXP_SUB_BRW = 8'hFE;
    localparam logic [7:0] EXP_ACC4    = 8'h00;
`endif

    localparam logic [1:0] RM [3] = '{2'b00, 2'b01, 2'b11};
    localparam logic [7:0] RA [3] = '{8'h10, 8'h30, 8'h0F};
    localparam logic [7:0] RB [3] = '{8'h01, 8'h10, 8'h00};

    led_adder_pipe #(.WIDTH(8), .BLINK_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .a_in(a_in), .b_in(b_in), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_carry(out_carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc_q(acc_q), .led(led)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] model_op(input logic [1:0] m, input logic [7:0] a,
                                            input logic [7:0] b, input logic [7:0] acc);
        int s;
        logic c;
        logic [7:0] d;
        case (m)
            2'b00:   s = int'(a) + int'(b);
            2'b01:   s = int'(a) - int'(b);
            2'b10:   s = int'(acc) + int'(a);
            default: s = 255 - int'(a);
        endcase
        c = (s > 255) || (s < 0);
        d = s[7:0];
`ifdef LED_ADDER_SATURATE_EN
        if (c) d = (s < 0) ? 8'h00 : 8'hFF;
`endif
        return {c, d};
    endfunction

    // One clock: drive at negedge, check handshake/outputs against the model, advance.
    task automatic cycle(input logic v, input logic [1:0] m, input logic [7:0] a,
                         input logic [7:0] b, input logic rdy, input logic en,
                         output logic acc_o);
        logic       exp_ready, led_nx;
        logic [8:0] exp_r;
        @(negedge clk);
        in_valid = v; mode = m; a_in = a; b_in = b; out_ready = rdy; ena = en;
        #1;
        exp_ready = en & (~m_valid | rdy);
        checks++;
        if (in_ready !== exp_ready) begin
            errors++; $display("FAIL in_ready got %b want %b", in_ready, exp_ready);
        end
        checks++;
        if (out_valid !== m_valid) begin
            errors++; $display("FAIL out_valid got %b want %b", out_valid, m_valid);
        end
        checks++;
        if (acc_q !== m_acc) begin
            errors++; $display("FAIL acc_q got %h want %h", acc_q, m_acc);
        end
        checks++;
        if (led !== m_led) begin
            errors++; $display("FAIL led got %b want %b", led, m_led);
        end
        if (m_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++; $display("FAIL scoreboard_empty got %h want none", {out_carry, out_data});
            end else begin
                if ({out_carry, out_data} !== sb[0]) begin
                    errors++; $display("FAIL result got %h want %h", {out_carry, out_data}, sb[0]);
                end
                if (rdy) exp_r = sb.pop_front();
            end
        end
        acc_o  = v & exp_ready;
        led_nx = m_sticky | m_cnt[3];
        if (acc_o) begin
            exp_r = model_op(m, a, b, m_acc);
            sb.push_back(exp_r);
            if (m == 2'b10) m_acc = exp_r[7:0];
            if (exp_r[8]) m_sticky = 1'b1;
            m_valid = 1'b1;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        if (en) m_cnt = m_cnt + 4'd1;
        m_led = led_nx;
        @(posedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ena = 1'b1;
        mode = 2'b00; a_in = 8'h00; b_in = 8'h00;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_valid = 1'b0; m_acc = 8'h00; m_sticky = 1'b0; m_cnt = 4'h0; m_led = 1'b0;
        sb.delete();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++;
        if (out_data !== 8'h00 || out_carry !== 1'b0) begin
            errors++; $display("FAIL rst_out_data got %h/%b want 00/0", out_data, out_carry);
        end
        checks++;
        if (acc_q !== 8'h00) begin errors++; $display("FAIL rst_acc got %h want 00", acc_q); end
        checks++;
        if (led !== 1'b0) begin errors++; $display("FAIL rst_led got %b want 0", led); end
    endtask

    task automatic test_reset();
        logic acc;
        do_reset(3);
        repeat (8) cycle(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, acc);
        #1; checks++;
        if (led !== 1'b0) begin errors++; $display("FAIL blink_low8 got %b want 0", led); end
        cycle(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, acc);
        #1; checks++;
        if (led !== 1'b1) begin errors++; $display("FAIL blink_rise got %b want 1", led); end
        repeat (7) cycle(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, acc);
        #1; checks++;
        if (led !== 1'b1) begin errors++; $display("FAIL blink_high16 got %b want 1", led); end
        cycle(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, acc);
        #1; checks++;
        if (led !== 1'b0) begin errors++; $display("FAIL blink_fall got %b want 0", led); end
    endtask

    task automatic test_add();
        logic acc;
        cycle(1'b1, 2'b00, 8'h12, 8'h34, 1'b1, 1'b1, acc);
        #1; checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h46 || out_carry !== 1'b0) begin
            errors++; $display("FAIL add got v%b %h c%b want v1 46 c0", out_valid, out_data, out_carry);
        end
        cycle(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, acc);
    endtask

    task automatic test_wrap();
        logic acc;
        cycle(1'b1, 2'b00, 8'hF0, 8'h20, 1'b1, 1'b1, acc);
        #1; checks++;
        if (out_data !== EXP_ADD_OVF || out_carry !== 1'b1) begin
            errors++; $display("FAIL add_ovf got %h c%b want %h c1", out_data, out_carry, EXP_ADD_OVF);
        end
        cycle(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, acc);
        #1; checks++;
        if (led !== 1'b1) begin errors++; $display("FAIL led_solid got %b want 1", led); end
        cycle(1'b1, 2'b01, 8'h05, 8'h07, 1'b1, 1'b1, acc);
        #1; checks++;
        if (out_data !== EXP_SUB_BRW || out_carry !== 1'b1) begin
            errors++; $display("FAIL sub_borrow got %h c%b want %h c1", out_data, out_carry, EXP_SUB_BRW);
        end
        repeat (10) cycle(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, acc);
    endtask

    task automatic test_back_to_back();
        logic acc;
        int   n_acc = 0;
        cycle(1'b1, 2'b00, 8'h01, 8'h02, 1'b1, 1'b1, acc); n_acc += int'(acc);
        cycle(1'b1, 2'b01, 8'h09, 8'h03, 1'b1, 1'b1, acc); n_acc += int'(acc);
        cycle(1'b1, 2'b11, 8'h5A, 8'hFF, 1'b1, 1'b1, acc); n_acc += int'(acc);
        #1; checks++;
        if (out_data !== 8'hA5 || out_carry !== 1'b0) begin
            errors++; $display("FAIL not got %h c%b want a5 c0", out_data, out_carry);
        end
        cycle(1'b1, 2'b00, 8'hFF, 8'h01, 1'b1, 1'b1, acc); n_acc += int'(acc);
        cycle(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, acc);
        checks++;
        if (n_acc !== 4) begin errors++; $display("FAIL b2b_accepts got %0d want 4", n_acc); end
    endtask

    task automatic test_backpressure();
        logic acc;
        int   idx = 0;
        int   n = 0;
        for (int c = 0; c < 4; c++) begin
            cycle(1'b1, RM[idx], RA[idx], RB[idx], 1'b0, 1'b1, acc);
            if (acc) idx++;
            #1; checks++;
            if (in_ready !== 1'b0 || out_data !== 8'h11) begin
                errors++; $display("FAIL hold got rdy%b %h want rdy0 11", in_ready, out_data);
            end
        end
        checks++;
        if (idx !== 1) begin errors++; $display("FAIL bp_accepts got %0d want 1", idx); end
        while (idx < 3 && n < 10) begin
            cycle(1'b1, RM[idx], RA[idx], RB[idx], 1'b1, 1'b1, acc);
            if (acc) idx++;
            n++;
        end
        checks++;
        if (idx !== 3 || n !== 2) begin
            errors++; $display("FAIL stream got %0d accepts in %0d cycles want 3 in 2", idx, n);
        end
        cycle(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, acc);
        #1; checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            errors++; $display("FAIL drain got v%b pending %0d want v0 pending 0", out_valid, sb.size());
        end
    endtask

    task automatic test_accumulate();
        logic       acc;
        logic [7:0] exp_acc [4];
        exp_acc[0] = 8'h40; exp_acc[1] = 8'h80; exp_acc[2] = 8'hC0; exp_acc[3] = EXP_ACC4;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 2'b10, 8'h40, 8'h55, 1'b1, 1'b1, acc);
            #1; checks++;
            if (acc_q !== exp_acc[i] || out_carry !== (i == 3)) begin
                errors++; $display("FAIL acc%0d got %h c%b want %h c%b", i, acc_q, out_carry, exp_acc[i], (i == 3));
            end
        end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL acc_pending got %b want 1", out_valid); end
        do_reset(1);
    endtask

    task automatic test_ena();
        logic acc;
        repeat (2) cycle(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, acc);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 2'b00, 8'h01, 8'h01, 1'b1, 1'b0, acc);
            #1; checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++; $display("FAIL ena_off got rdy%b v%b want rdy0 v0", in_ready, out_valid);
            end
        end
        repeat (6) cycle(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, acc);
        #1; checks++;
        if (led !== 1'b0) begin errors++; $display("FAIL frozen_lo got %b want 0", led); end
        cycle(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, acc);
        #1; checks++;
        if (led !== 1'b1) begin errors++; $display("FAIL frozen_hi got %b want 1", led); end
        repeat (12) cycle(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, acc);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        mode = 2'b00; a_in = 8'h00; b_in = 8'h00;
        m_valid = 1'b0; m_sticky = 1'b0; m_led = 1'b0; m_acc = 8'h00; m_cnt = 4'h0;
        test_reset();
        test_add();
        test_wrap();
        test_back_to_back();
        test_backpressure();
        test_accumulate();
        test_ena();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
